hash_nonce_scheduler: RTL

Sequences the nonce search for one mining job: issues one nonce per cycle to the pipelined hash datapath, tracks the nonces still in flight, and checks each returned hash against the target. It stops on the first qualifying hash and reports that nonce and hash. It sits between the job source (block bytes, target, start) and the hash core, and replaces free-running nonce generation with a controlled start/drain/done sequence.

---
 rtl/hash_nonce_scheduler_pkg.sv | 23 ++
 rtl/hash_nonce_scheduler_tag_line.sv | 46 ++++
 rtl/hash_nonce_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hash_nonce_scheduler_pkg.sv
// Shared types and helpers for the nonce search scheduler.
package hash_nonce_scheduler_pkg;

  localparam int unsigned BLOQUE_W = 96;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned HASH_W   = 24;
  localparam int unsigned TARGET_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // A hash qualifies when both of its upper two bytes are below the target.
  function automatic logic hash_cumple(input logic [HASH_W-1:0]   hash,
                                       input logic [TARGET_W-1:0] tgt);
    return (hash[HASH_W-1 -: TARGET_W] < tgt) &&
           (hash[HASH_W-TARGET_W-1 -: TARGET_W] < tgt);
  endfunction

endpackage

// File: rtl/hash_nonce_scheduler_tag_line.sv
// nonce_tag_line: DEPTH-deep {valid, nonce} delay line that mirrors the hash
// core pipeline, so the tail entry lines up with the core result.
module nonce_tag_line
  import hash_nonce_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  input  logic [NONCE_W-1:0] in_nonce_i,
  output logic               tail_valid_o,
  output logic [NONCE_W-1:0] tail_nonce_o,
  output logic               empty_o
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [NONCE_W-1:0] nonce_q [DEPTH];
  logic [NONCE_W-1:0] nonce_d [DEPTH];

  // Shift every entry one stage towards the tail.
  always_comb begin
    valid_d[0] = in_valid_i;
    nonce_d[0] = in_nonce_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      nonce_d[i] = nonce_q[i-1];
    end
  end

  // Delay line registers; reset empties the line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) nonce_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(DEPTH); i++) nonce_q[i] <= nonce_d[i];
    end
  end

  assign tail_valid_o = valid_q[DEPTH-1];
  assign tail_nonce_o = nonce_q[DEPTH-1];
  assign empty_o      = ~|valid_q;

endmodule

// File: rtl/hash_nonce_scheduler.sv
// hash_nonce_scheduler: issues one nonce per cycle to the hash core, checks
// returned hashes against the captured target and stops on the first match.
// Optional abort input is enabled with the HASH_SCHED_ABORT_EN macro.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for inicio
// ST_RUN   | issuing nonces, checking returned hashes
// ST_DRAIN | issue stopped, waiting for in-flight nonces to return
// ST_DONE  | job reported; outputs held until the next inicio
module hash_nonce_scheduler
  import hash_nonce_scheduler_pkg::*;
#(
  parameter int unsigned        HASH_LAT   = 3,
  parameter logic [NONCE_W-1:0] NONCE_LAST = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inicio,
  input  logic [BLOQUE_W-1:0] bloque_bytes,
  input  logic [TARGET_W-1:0] target,
`ifdef HASH_SCHED_ABORT_EN
  input  logic                abortar,
`endif
  output logic [BLOQUE_W-1:0] core_bloque,
  output logic [NONCE_W-1:0]  core_nonce,
  output logic                core_valid,
  input  logic [HASH_W-1:0]   core_hash,
  output logic                ocupado,
  output logic                terminado,
  output logic                encontrado,
  output logic [NONCE_W-1:0]  nonce_out,
  output logic [HASH_W-1:0]   hash_out
);

  sched_state_e        state_q, state_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [BLOQUE_W-1:0] bloque_q, bloque_d;
  logic [TARGET_W-1:0] target_q, target_d;
  logic                encontrado_q, encontrado_d;
  logic [NONCE_W-1:0]  nonce_out_q, nonce_out_d;
  logic [HASH_W-1:0]   hash_out_q, hash_out_d;

  logic                issue;
  logic                match;
  logic                abort_req;
  logic                tail_valid;
  logic [NONCE_W-1:0]  tail_nonce;
  logic                tag_empty;

`ifdef HASH_SCHED_ABORT_EN
  assign abort_req = abortar;
`else
  assign abort_req = 1'b0;
`endif

  nonce_tag_line #(
    .DEPTH(HASH_LAT)
  ) u_tag_line (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (issue),
    .in_nonce_i  (nonce_q),
    .tail_valid_o(tail_valid),
    .tail_nonce_o(tail_nonce),
    .empty_o     (tag_empty)
  );

  // Next-state, nonce issue and first-match capture.
  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    bloque_d     = bloque_q;
    target_d     = target_q;
    encontrado_d = encontrado_q;
    nonce_out_d  = nonce_out_q;
    hash_out_d   = hash_out_q;
    issue        = 1'b0;
    match        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (inicio) begin
          bloque_d     = bloque_bytes;
          target_d     = target;
          nonce_d      = '0;
          encontrado_d = 1'b0;
          nonce_out_d  = '0;
          hash_out_d   = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // encontrado is always clear in RUN, the first match ends issuing
        match = tail_valid && hash_cumple(core_hash, target_q);
        if (match) begin
          encontrado_d = 1'b1;
          nonce_out_d  = tail_nonce;
          hash_out_d   = core_hash;
          state_d      = ST_DRAIN;
        end else if (abort_req) begin
          state_d = ST_DRAIN;
        end else begin
          issue = 1'b1;
          if (nonce_q == NONCE_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Results of nonces issued before the stop still count, first one wins
        match = tail_valid && !encontrado_q && hash_cumple(core_hash, target_q);
        if (match) begin
          encontrado_d = 1'b1;
          nonce_out_d  = tail_nonce;
          hash_out_d   = core_hash;
        end
        if (tag_empty) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and job registers; reset aborts any job without reporting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      nonce_q      <= '0;
      bloque_q     <= '0;
      target_q     <= '0;
      encontrado_q <= 1'b0;
      nonce_out_q  <= '0;
      hash_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      nonce_q      <= nonce_d;
      bloque_q     <= bloque_d;
      target_q     <= target_d;
      encontrado_q <= encontrado_d;
      nonce_out_q  <= nonce_out_d;
      hash_out_q   <= hash_out_d;
    end
  end

  assign core_bloque = bloque_q;
  assign core_nonce  = nonce_q;
  assign core_valid  = issue;
  assign ocupado     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign terminado   = (state_q == ST_DONE);
  assign encontrado  = encontrado_q;
  assign nonce_out   = nonce_out_q;
  assign hash_out    = hash_out_q;

endmodule
